// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional perf counters in mem_arbiter are enabled by MEM_ARB_PERF_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic GNT_CORE = 1'b0;
  localparam logic GNT_LD   = 1'b1;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational two-way round-robin picker: on a tie the side not granted last wins.
// Zero latency; no backpressure, caller samples grant only when it can accept.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic core_pend,
  input  logic ld_pend,
  input  logic last_grant,
  output logic gnt_vld,
  output logic gnt_id
);

  always_comb begin
    gnt_vld = core_pend | ld_pend;
    gnt_id  = GNT_CORE;
    if (core_pend && ld_pend) begin
      gnt_id = ~last_grant;
    end else if (ld_pend) begin
      gnt_id = GNT_LD;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port data memory between core and loader: 1 + WAIT_CYCLES + 1 cycles per access.
// Core is held by core_stall, loader waits for ld_ack; MEM_ARB_PERF_EN adds grant counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              core_re,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_core_cnt,
  output logic [15:0]       perf_ld_cnt
`endif
);

  localparam logic [WAIT_W-1:0] CNT_LOAD = WAIT_W'(WAIT_CYCLES - 1);

  state_t            state;
  logic [WAIT_W-1:0] cnt;
  logic              grant;
  logic              last_grant;
  logic              gnt_vld;
  logic              gnt_id;

  mem_arb_rr u_rr (
    .core_pend  (core_re | core_we),
    .ld_pend    (ld_req),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .gnt_id     (gnt_id)
  );

  // The core is released only in its own RESP cycle, so it advances exactly once per access.
  assign core_stall = (core_re | core_we) & ~((state == RESP) & (grant == GNT_CORE));

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      grant      <= GNT_CORE;
      last_grant <= GNT_LD;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rdata <= '0;
      ld_rdata   <= '0;
      ld_ack     <= 1'b0;
    end else begin
      ld_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            grant      <= gnt_id;
            last_grant <= gnt_id;
            cnt        <= CNT_LOAD;
            mem_en     <= 1'b1;
            state      <= BUSY;
            if (gnt_id == GNT_LD) begin
              mem_we    <= ld_we;
              mem_addr  <= ld_addr;
              mem_wdata <= ld_wdata;
            end else begin
              // Simultaneous read and write from the core resolves to a write.
              mem_we    <= core_we;
              mem_addr  <= core_addr;
              mem_wdata <= core_wdata;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            state  <= RESP;
            ld_ack <= (grant == GNT_LD);
            if (!mem_we) begin
              if (grant == GNT_LD) begin
                ld_rdata <= mem_rdata;
              end else begin
                core_rdata <= mem_rdata;
              end
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      perf_core_cnt <= '0;
      perf_ld_cnt   <= '0;
    end else if (state == RESP) begin
      if (grant == GNT_CORE) begin
        if (perf_core_cnt != 16'hFFFF) perf_core_cnt <= perf_core_cnt + 16'd1;
      end else begin
        if (perf_ld_cnt != 16'hFFFF) perf_ld_cnt <= perf_ld_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single-port 8-bit data memory between the nRisc core data port and an external loader/debug port.
- The core side is driven by the core's LerMem/EscrevMem and register operands. Read data is returned to the core's from_mem input.
- The loader side preloads and inspects memory over a req/ack handshake.
- Generates a stall to freeze the core for multi-cycle memory accesses.

Parameters:
- DATA_W, 8, data width
- ADDR_W, 8, address width
- WAIT_CYCLES, 1, cycles mem_en is held per access before mem_rdata is valid; legal range 1..15

Ports:
- Clock  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- core_re  in  1  core read request (LerMem)
- core_we  in  1  core write request (EscrevMem)
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core store data
- core_rdata  out  DATA_W  registered load data to core (from_mem)
- core_stall  out  1  core must hold PC/state while high
- ld_req  in  1  loader request, level
- ld_we  in  1  loader write (1) / read (0)
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_ack  out  1  one-cycle completion pulse
- ld_rdata  out  DATA_W  registered loader read data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (async, Reset_n=0):
  - State=IDLE, wait counter=0, last_grant=LD.
  - All outputs 0, so core_stall=0 unless a core request is present (combinational term, see below).
  - An in-flight access is aborted; mem_en/mem_we drop immediately.
- FSM states IDLE, BUSY, RESP:
  - IDLE:
    - Core is pending when core_re|core_we is high; loader is pending when ld_req is high.
    - If both are pending, grant the requester not in last_grant (round robin). After reset, the core therefore wins the first tie.
    - On grant, latch addr, wdata and we into internal registers. If core_re and core_we are both high, treat as a write.
    - Load counter=WAIT_CYCLES-1, update last_grant, go to BUSY.
    - With no request, stay in IDLE.
  - BUSY:
    - mem_en=1; mem_we/mem_addr/mem_wdata come from the latched registers and stay stable for all WAIT_CYCLES cycles.
    - Counter decrements each cycle. When counter==0 on a read, capture mem_rdata into core_rdata or ld_rdata (per grant) at that edge, then go to RESP.
    - Writes take the same WAIT_CYCLES; rdata registers are unchanged.
  - RESP:
    - mem_en=0.
    - Grant=LD: ld_ack=1 for this cycle. Grant=CORE: core_stall=0 for this cycle.
    - Always return to IDLE next cycle; every access is followed by one IDLE bubble.
- core_stall = (core_re|core_we) & ~(state==RESP & grant==CORE), combinational.
  - A core request raises stall in the same cycle. The core advances only on the RESP edge.
  - A new core request in the following cycle is arbitrated in IDLE.
- Loader protocol:
  - Hold ld_req and its operands until ld_ack.
  - Deassert ld_req on the edge where ld_ack=1. A req still high in the next IDLE is served again.
- core_rdata and ld_rdata hold their value until the next read by the same requester.
- Latency per access: 1 (IDLE) + WAIT_CYCLES (BUSY) + 1 (RESP) cycles.
- Operands that change while BUSY are ignored, since the access uses the latched values.
- Address wraps naturally at 2^ADDR_W; no range checking.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_core_cnt and perf_ld_cnt, 16 bits each.
  - Each counts completed grants (increments in RESP), saturates at 16'hFFFF and is cleared by reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - State encoding IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - Grant constants GNT_CORE=1'b0, GNT_LD=1'b1.
  - Counter width constant WAIT_W=4.
- One sub-module, mem_arb_rr: combinational round-robin picker.
  - Inputs: core pending, ld pending, last_grant.
  - Outputs: grant valid, grant id.

Test Plan:
- Reset release, no requests -> mem_en=0, core_stall=0, ld_ack=0, state stays IDLE for 10 cycles.
- WAIT_CYCLES=1, core_re=1, core_addr=8'h10, mem returns 8'hA5 -> stall high 2 cycles, low in RESP; core_rdata=8'hA5; mem_en high exactly 1 cycle.
- Loader write ld_addr=8'h20, ld_wdata=8'h3C, then loader read of 8'h20 -> mem_we=1 with addr 8'h20/data 8'h3C during BUSY; second ack gives ld_rdata=8'h3C.
- core and ld request in the same IDLE cycle after reset, both held -> core served first, loader second, then core again (alternation), no starvation.
- WAIT_CYCLES=3, core_we=1 and core_re=1 together -> treated as write; mem_en high 3 cycles; core_rdata unchanged.
- Reset_n pulled low mid-BUSY -> mem_en/mem_we drop asynchronously; after release state=IDLE and last_grant=LD; with MEM_ARB_PERF_EN defined, counters read 0.
